// File: rtl/nokia_lcd_ctrl_if.sv
// Bus between the Nokia LCD controller, its framebuffer, the SPI byte
// engine and whoever requests frame refreshes.
interface nokia_lcd_ctrl_if;
  logic       refresh;
  logic [7:0] fb_data;
  logic [8:0] fb_addr;
  logic       spi_avail;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_command;
  logic       ready;
  logic       busy;
  logic       frame_done;

  modport master (
    input  refresh, fb_data, spi_avail,
    output fb_addr, spi_start, spi_data, spi_command, ready, busy, frame_done
  );

  modport slave (
    output refresh, fb_data, spi_avail,
    input  fb_addr, spi_start, spi_data, spi_command, ready, busy, frame_done
  );
endinterface

// File: rtl/nokia_lcd_ctrl.sv
// Nokia 5110-style LCD controller: power-up delay, 6-byte init sequence,
// then on refresh streams a 2-byte address header plus 504 framebuffer
// bytes to an external SPI byte engine.
module nokia_lcd_ctrl #(
  parameter int         PWR_DLY = 1000,
  parameter logic [6:0] VOP     = 7'h31,
  parameter logic [2:0] BIAS    = 3'h3,
  parameter logic [1:0] TEMPC   = 2'h0
) (
  input  logic              clk,
  input  logic              reset,
  nokia_lcd_ctrl_if.master  bus
);

  localparam int         DW       = (PWR_DLY < 1) ? 1 : $clog2(PWR_DLY + 1);
  localparam logic [8:0] LAST_ADR = 9'd503;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_ISSUE, INIT_WAIT, IDLE,
    HDR_ISSUE, HDR_WAIT, FETCH, DATA_ISSUE, DATA_WAIT
  } state_t;

  state_t        state;
  logic [DW-1:0] dly_cnt;
  logic [2:0]    init_idx;
  logic          hdr_idx;
  logic          fetch_ph;
  logic          wait_first;
  logic          pending;
  logic [7:0]    data_reg;
  logic [8:0]    fb_addr;
  logic          spi_start;
  logic [7:0]    spi_data;
  logic          spi_command;
  logic          ready;
  logic          busy;
  logic          frame_done;

  assign bus.fb_addr     = fb_addr;
  assign bus.spi_start   = spi_start;
  assign bus.spi_data    = spi_data;
  assign bus.spi_command = spi_command;
  assign bus.ready       = ready;
  assign bus.busy        = busy;
  assign bus.frame_done  = frame_done;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h21;               // extended instruction set
      3'd1:    init_byte = {1'b1, VOP};         // contrast
      3'd2:    init_byte = {6'b000001, TEMPC};  // temperature coefficient
      3'd3:    init_byte = {5'b00010, BIAS};    // bias system
      3'd4:    init_byte = 8'h20;               // back to basic set
      default: init_byte = 8'h0C;               // normal display mode
    endcase
  endfunction

  // Main sequencer; every output is registered. A *_WAIT state skips its
  // first cycle because the SPI engine only drops avail one clock after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PWR_WAIT;
      dly_cnt     <= '0;
      init_idx    <= '0;
      hdr_idx     <= 1'b0;
      fetch_ph    <= 1'b0;
      wait_first  <= 1'b0;
      pending     <= 1'b0;
      data_reg    <= 8'h00;
      fb_addr     <= 9'd0;
      spi_start   <= 1'b0;
      spi_data    <= 8'h00;
      spi_command <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      frame_done <= 1'b0;
      // Requests arriving while busy collapse into one pending frame.
      if (bus.refresh && state != IDLE) pending <= 1'b1;
      case (state)
        PWR_WAIT: begin
          if (dly_cnt != DW'(PWR_DLY)) dly_cnt <= dly_cnt + 1'b1;
          else if (bus.spi_avail) begin
            init_idx <= '0;
            state    <= INIT_ISSUE;
          end
        end
        INIT_ISSUE: begin
          if (bus.spi_avail) begin
            spi_start   <= 1'b1;
            spi_data    <= init_byte(init_idx);
            spi_command <= 1'b0;
            wait_first  <= 1'b1;
            state       <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (wait_first) wait_first <= 1'b0;
          else if (bus.spi_avail) begin
            if (init_idx == 3'd5) begin
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
              state    <= INIT_ISSUE;
            end
          end
        end
        IDLE: begin
          if (bus.refresh || pending) begin
            pending <= 1'b0;
            hdr_idx <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= HDR_ISSUE;
          end
        end
        HDR_ISSUE: begin
          if (bus.spi_avail) begin
            spi_start   <= 1'b1;
            spi_data    <= hdr_idx ? 8'h40 : 8'h80;
            spi_command <= 1'b0;
            wait_first  <= 1'b1;
            state       <= HDR_WAIT;
          end
        end
        HDR_WAIT: begin
          if (wait_first) wait_first <= 1'b0;
          else if (bus.spi_avail) begin
            if (hdr_idx) begin
              fetch_ph <= 1'b0;
              state    <= FETCH;
            end else begin
              hdr_idx <= 1'b1;
              state   <= HDR_ISSUE;
            end
          end
        end
        FETCH: begin
          // Phase 0: address presented to the framebuffer; phase 1: capture.
          if (!fetch_ph) fetch_ph <= 1'b1;
          else begin
            data_reg <= bus.fb_data;
            state    <= DATA_ISSUE;
          end
        end
        DATA_ISSUE: begin
          if (bus.spi_avail) begin
            spi_start   <= 1'b1;
            spi_data    <= data_reg;
            spi_command <= 1'b1;
            wait_first  <= 1'b1;
            state       <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (wait_first) wait_first <= 1'b0;
          else if (bus.spi_avail) begin
            if (fb_addr == LAST_ADR) begin
              fb_addr    <= 9'd0;
              frame_done <= 1'b1;
              ready      <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              fb_addr  <= fb_addr + 1'b1;
              fetch_ph <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: doc/nokia_lcd_ctrl.md
NOKIA_LCD_CTRL -- requirements
Module: nokia_lcd_ctrl

Interface
REQ-001 SHALL have parameters: PWR_DLY, default 1000, clocks from reset release to first command; VOP, default 7'h31, contrast value; BIAS, default 3'h3; TEMPC, default 2'h0.
REQ-002 SHALL have ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- refresh  in  1  one-cycle frame-refresh request.
- fb_data  in  8  framebuffer read data, valid 1 cycle after fb_addr.
- fb_addr  out  9  framebuffer byte address, 0..503.
- spi_avail  in  1  spi_master avail (idle / byte done).
- spi_start  out  1  spi_master start strobe.
- spi_data  out  8  byte to spi_master data_in.
- spi_command  out  1  to spi_master command: 0 = command byte, 1 = display-RAM data.
- ready  out  1  init complete, idle.
- busy  out  1  init or frame transfer in progress.
- frame_done  out  1  one-cycle pulse after the last byte of a frame completes.

Function
REQ-003 States SHALL be PWR_WAIT, INIT_ISSUE, INIT_WAIT, IDLE, HDR_ISSUE, HDR_WAIT, FETCH, DATA_ISSUE, DATA_WAIT.
REQ-004 PWR_WAIT SHALL count PWR_DLY clocks, then wait for spi_avail=1, then go to INIT_ISSUE with init index 0.
REQ-005 Init sequence SHALL be 6 command bytes, in order:
- 0x21
- {1'b1, VOP}
- {6'b000001, TEMPC}
- {5'b00010, BIAS}
- 0x20
- 0x0C
With default parameters this is 0x21, 0xB1, 0x04, 0x13, 0x20, 0x0C.
REQ-006 Byte handshake, every *_ISSUE state:
- Issue only when spi_avail=1.
- Assert spi_start=1 for exactly one clock, with spi_data and spi_command valid in that clock.
- Then move to the matching *_WAIT state.
REQ-007 *_WAIT SHALL ignore spi_avail in its first cycle, then leave only on spi_avail=1.
REQ-008 After the 6th init byte completes, the block SHALL enter IDLE, with ready=1 and busy=0.
REQ-009 In IDLE, refresh=1 or pending=1 SHALL clear pending and enter HDR_ISSUE.
REQ-010 Header SHALL be 2 command bytes, 0x80 then 0x40 (X=0, Y=0), with spi_command=0.
REQ-011 FETCH SHALL present fb_addr for one clock and register fb_data on the next clock, then enter DATA_ISSUE.
REQ-012 DATA_ISSUE SHALL send the registered byte with spi_command=1.
REQ-013 After each data byte completes:
- fb_addr < 503: increment fb_addr and return to FETCH.
- fb_addr = 503: set fb_addr to 0, pulse frame_done for one clock, return to IDLE.
REQ-014 Exactly 504 data bytes per frame, sent in address order 0..503, with no skip or duplicate.
REQ-015 refresh=1 outside IDLE (including during init) SHALL set the 1-bit pending flag; multiple requests SHALL collapse into one.
REQ-016 refresh=1 in the same cycle a frame completes SHALL leave pending=1, so one more frame follows immediately.
REQ-017 spi_start SHALL never be asserted while spi_avail=0, nor in two consecutive cycles.
REQ-018 busy SHALL be 1 in all states except IDLE; ready SHALL be 1 only in IDLE.
REQ-019 spi_data and spi_command SHALL hold their last values outside issue cycles.

Reset
REQ-020 While reset=1 the block SHALL asynchronously force, in the same cycle:
- state=PWR_WAIT, delay counter=0, init index=0, pending=0.
- fb_addr=0, spi_start=0, spi_data=0x00, spi_command=0.
- ready=0, busy=1, frame_done=0.
REQ-021 Reset asserted mid-frame or mid-init SHALL abort the transfer; after release the full power-up delay and init sequence SHALL rerun.

Verification
REQ-022 Bench SHALL use spi_master with div_factor=2 and a 504-byte framebuffer model with 1-cycle read latency holding fb[i]=i[7:0]. It SHALL cover:
- Power-up with PWR_DLY=16: no spi_start before 16 clocks plus avail. Decoded (dc, byte) sequence SHALL be (0,21),(0,B1),(0,04),(0,13),(0,20),(0,0C). Then ready=1.
- Single refresh pulse in IDLE: SHALL produce (0,80),(0,40), then 504 bytes with dc=1 and values 00..FF,00..F7. Exactly one frame_done pulse; fb_addr returns to 0.
- Three refresh pulses during one frame: SHALL produce exactly one extra back-to-back frame, then IDLE.
- refresh during init: first frame SHALL start right after the 0x0C byte completes.
- Reset at data byte 200: all outputs SHALL take their reset values immediately. Restart SHALL re-emit the 6 init bytes, and no frame SHALL start without a new refresh.
- Protocol checker for the whole run: spi_start only when spi_avail=1 and never on consecutive cycles; byte count per frame = 504.
